// File: rtl/sev_seg_pkg.sv
// Shared constants, FSM state type and helpers for the multiplexed seven-segment driver.
// Segment patterns are {g,f,e,d,c,b,a} in active-low form.
package sev_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [31:0] pow10_minus1(input int unsigned n);
        logic [31:0] p;
        p = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        if (n > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[n];
    endfunction

endpackage

// File: rtl/sev_seg_mux_driver_bin2bcd.sv
// Serial shift-add-3 binary-to-BCD converter: one input bit per cycle after start.
// done is high during the final shift; the result is valid on the following cycle.
module bin2bcd_serial #(
    parameter int BIN_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    // One guard nibble absorbs inputs beyond the displayable range.
    localparam int ACC_W = 4 * NUM_DIGITS + 4;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_sr;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] adj;
    logic [CNT_W-1:0] cnt;
    logic             active;

    always_comb begin
        adj = acc;
        for (int unsigned i = 0; i < NUM_DIGITS + 1; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr <= '0;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            bin_sr <= bin_in;
            acc    <= '0;
            cnt    <= CNT_W'(BIN_W - 1);
            active <= 1'b1;
        end else if (active) begin
            {acc, bin_sr} <= {adj, bin_sr} << 1;
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign done = active && (cnt == '0);
    assign bcd  = acc[4*NUM_DIGITS-1:0];

endmodule

// File: rtl/sev_seg_mux_driver.sv
// Multi-digit multiplexed seven-segment driver with serial BCD conversion and digit scanner.
// Optional macro SEV_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module sev_seg_mux_driver
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [BIN_W-1:0]      binVal,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            segOut,
    output logic [NUM_DIGITS-1:0] digitEn
);

    localparam int          DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0] LIMIT   = pow10_minus1(NUM_DIGITS);
    localparam bit          POL_LOW = (ACTIVE_LOW != 0);

    state_t                    state, state_nxt;
    logic                      start;
    logic                      conv_done;
    logic [4*NUM_DIGITS-1:0]   bcd;
    logic                      ovf_pend;
    logic [3:0]                digit_reg [NUM_DIGITS];
    logic [DIV_W-1:0]          div;
    logic [IDX_W-1:0]          idx;
    logic [6:0]                seg_al;
    logic [NUM_DIGITS-1:0]     en_al;

    bin2bcd_serial #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bin_in (binVal),
        .done   (conv_done),
        .bcd    (bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT:   if (conv_done) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
            overflow <= 1'b0;
            ovf_pend <= 1'b0;
        end else begin
            if (start) begin
                ovf_pend <= (32'(binVal) > LIMIT);
            end
            if (state == COMMIT) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    digit_reg[i] <= bcd[4*i +: 4];
                end
                overflow <= ovf_pend;
            end
        end
    end

`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] blank_nxt;
    logic                  seen;

    // Walk down from the top digit; a digit blanks until the first nonzero one is seen.
    always_comb begin
        blank_nxt = '0;
        seen      = 1'b0;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            blank_nxt[i] = !seen;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_mask <= '0;
        end else if (state == COMMIT) begin
            blank_mask <= blank_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(CLK_DIV - 1)) begin
            div <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_comb begin
        seg_al = seg_encode(digit_reg[idx]);
`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
        if (blank_mask[idx]) begin
            seg_al = SEG_BLANK;
        end
`endif
        if (overflow) begin
            seg_al = SEG_DASH;
        end
        en_al = ~(NUM_DIGITS'(1) << idx);
    end

    // Segment and enable share one register stage so they switch together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segOut  <= POL_LOW ? '1 : '0;
            digitEn <= POL_LOW ? '1 : '0;
        end else begin
            segOut  <= POL_LOW ? seg_al : ~seg_al;
            digitEn <= POL_LOW ? en_al : ~en_al;
        end
    end

endmodule

// File: tb/tb_sev_seg_mux_driver.sv
// Self-checking bench: randomized loads against an arithmetic display model plus directed scenarios.
module tb_sev_seg_mux_driver;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int CD = 4;
    localparam bit AL = 1'b1;
    localparam int LIM = 9999;

    localparam logic [6:0] SEGT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };
    localparam int P10 [0:4] = '{1, 10, 100, 1000, 10000};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0;
    logic [BW-1:0] binVal = '0;
    logic          busy;
    logic          overflow;
    logic [6:0]    segOut;
    logic [ND-1:0] digitEn;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: remaining busy cycles, pending/committed value, and what the scanner shows.
    int m_cnt, m_pend, m_val, sh_val, m_edges;
    bit m_ovf, sh_ovf;

    sev_seg_mux_driver #(
        .NUM_DIGITS (ND),
        .BIN_W      (BW),
        .CLK_DIV    (CD),
        .ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .binVal   (binVal),
        .busy     (busy),
        .overflow (overflow),
        .segOut   (segOut),
        .digitEn  (digitEn)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   <= 0;
            m_pend  <= 0;
            m_val   <= 0;
            m_ovf   <= 1'b0;
            sh_val  <= 0;
            sh_ovf  <= 1'b0;
            m_edges <= 0;
        end else begin
            m_edges <= m_edges + 1;
            sh_val  <= m_val;
            sh_ovf  <= m_ovf;
            if (m_cnt == 0) begin
                if (load) begin
                    m_cnt  <= BW + 1;
                    m_pend <= int'(binVal);
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_val <= m_pend;
                    m_ovf <= (m_pend > LIM);
                end
            end
        end
    end

    function automatic logic [ND-1:0] exp_en();
        logic [ND-1:0] r;
        int k;
        if (m_edges == 0) return AL ? '1 : '0;
        k = ((m_edges - 1) / CD) % ND;
        r = ~(ND'(1) << k);
        return AL ? r : ~r;
    endfunction

    function automatic logic [6:0] exp_seg();
        logic [6:0] r;
        int k, d;
        if (m_edges == 0) return AL ? 7'h7F : 7'h00;
        k = ((m_edges - 1) / CD) % ND;
        d = (sh_val / P10[k]) % 10;
        r = SEGT[d];
`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
        if (k > 0 && sh_val < P10[k]) r = 7'h7F;
`endif
        if (sh_ovf) r = 7'b0111111;
        return AL ? r : ~r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("model_busy", 32'(busy), 32'(m_cnt != 0));
            check("model_overflow", 32'(overflow), 32'(m_ovf));
            check("model_segOut", 32'(segOut), 32'(exp_seg()));
            check("model_digitEn", 32'(digitEn), 32'(exp_en()));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input int v);
        load   = 1'b1;
        binVal = BW'(v);
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic wait_digit(input int k, output logic [6:0] seg);
        logic [ND-1:0] want;
        int n;
        want = ~(ND'(1) << k);
        n = 0;
        do begin
            tick();
            n++;
        end while (digitEn !== want && n < 64);
        if (n >= 64) check("digit_wait", 32'(digitEn), 32'(want));
        seg = segOut;
    endtask

    task automatic run_stim();
        logic [6:0]    s;
        logic [ND-1:0] seq [0:4];
        logic [6:0]    upper;
        int c, v, hold, gap;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011;
        seq[3] = 4'b0111; seq[4] = 4'b1110;
`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
        upper = 7'b1111111;
`else
        upper = 7'b1000000;
`endif

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_segOut", 32'(segOut), 32'h7F);
        check("rst_digitEn", 32'(digitEn), 32'hF);
        tick(); tick();
        reset = 1'b0;
        tick();

        // 1234: busy length and digit 0 pattern
        do_load(1234);
        c = 0;
        while (busy && c < 100) begin
            c++;
            tick();
        end
        check("busy_len", 32'(c), 32'd15);
        wait_digit(0, s);
        check("d0_1234", 32'(s), 32'(7'b0011001));
        wait_digit(3, s);
        check("d3_1234", 32'(s), 32'(7'b1111001));

        // Overflow, then cleared by an in-range load
        do_load(10000);
        wait_idle();
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < ND; i++) begin
            wait_digit(i, s);
            check("ovf_dash", 32'(s), 32'(7'b0111111));
        end
        do_load(42);
        wait_idle();
        check("ovf_clear", 32'(overflow), 32'd0);
        wait_digit(1, s);
        check("d1_42", 32'(s), 32'(7'b0011001));
        wait_digit(0, s);
        check("d0_42", 32'(s), 32'(7'b0100100));

        // Leading digits of a small value
        do_load(7);
        wait_idle();
        wait_digit(0, s);
        check("d0_7", 32'(s), 32'(7'b1111000));
        for (int i = 1; i < ND; i++) begin
            wait_digit(i, s);
            check("dup_7", 32'(s), 32'(upper));
        end

        // Load while busy is ignored
        do_load(5678);
        tick(); tick();
        do_load(9999);
        wait_idle();
        wait_digit(3, s);
        check("d3_5678", 32'(s), 32'(7'b0010010));
        wait_digit(0, s);
        check("d0_5678", 32'(s), 32'(7'b0000000));

        // Reset in the middle of a conversion
        do_load(4321);
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_segOut", 32'(segOut), 32'h7F);
        check("midrst_digitEn", 32'(digitEn), 32'hF);
        tick();
        reset = 1'b0;

        // Idle scan from release: each digit held CD cycles, always one-cold
        for (int i = 0; i < 20; i++) begin
            tick();
            check("onecold", 32'($countones(~digitEn)), 32'd1);
            if (i % 4 == 0) check("scan_seq", 32'(digitEn), 32'(seq[i / 4]));
        end
        wait_digit(0, s);
        check("post_rst_d0", 32'(s), 32'(7'b1000000));
        wait_digit(2, s);
        check("post_rst_d2", 32'(s), 32'(upper));
        check("post_rst_ovf", 32'(overflow), 32'd0);

        // Randomized traffic, including held loads, boundary values and stray resets
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    c = $urandom_range(0, 7);
                    case (c)
                        0: v = 0;     1: v = 9;     2: v = 99;    3: v = 100;
                        4: v = 9999;  5: v = 10000; 6: v = 16383; default: v = 1000;
                    endcase
                end
                default: v = $urandom_range(0, 16383);
            endcase
            hold = $urandom_range(1, 20);
            load = 1'b1;
            for (int h = 0; h < hold; h++) begin
                binVal = BW'(v);
                tick();
                v = $urandom_range(0, 16383);
            end
            load = 1'b0;
            gap = $urandom_range(0, 40);
            repeat (gap) tick();
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        wait_idle();
        repeat (2 * CD * ND) tick();
    endtask

    initial begin
        #1;
        reset = 1'b1;
        #1;
        fork
            compare_loop();
            run_stim();
            begin
                #2000000;
                check("watchdog", 32'(busy), 32'hDEAD);
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
